lsu_mem_if: RTL and testbench
=============================

# lsu_mem_if

Parametrised load/store unit sitting between the core datapath and data memory, replacing the fixed single-cycle 32-bit memory path. Accepts one load/store per handshake, generates byte enables and store-data lane alignment, drives a request/grant/rvalid memory port with arbitrary latency, and returns sign- or zero-extended load data. Misaligned or unsupported accesses complete with an error and no memory access. Supports 32- and 64-bit data paths (RV32I/RV64I load/store subsets).

## Interface
- DATA_W, 32, data width; legal values 32 or 64
- ADDR_W, 9, memory word-address width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a load/store
- req_ready  out  1  unit can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the access
- req_addr  in  DATA_W  byte address (rs1 + imm)
- req_wdata  in  DATA_W  store data, unaligned (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  with resp_valid: misaligned/unsupported access
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- busy  out  1  stall request to core (any state but IDLE)
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  memory write
- mem_be  out  DATA_W/8  byte enables
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+OFF-1:OFF], OFF = log2(DATA_W/8)
- mem_wdata  out  DATA_W  lane-aligned store data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read word

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture we/funct3/addr/wdata. Legal → REQ; illegal → RESP with error.
- Size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 double (DATA_W=64 only). funct3[2]=1 → unsigned load.
- Illegal: size 11 when DATA_W=32; funct3[2]=1 on any store; funct3 111 on DATA_W=64; addr not aligned to size.
- mem_be = size mask shifted by addr[OFF-1:0]; mem_wdata = wdata replicated/shifted into that lane.
- REQ: mem_req=1 with stable mem_we/be/addr/wdata. On mem_gnt: store → RESP; load → WAIT.
- WAIT: on mem_rvalid, select lane by captured offset, sign/zero-extend into resp_rdata register → RESP.
- RESP: resp_valid=1 for exactly one cycle, → IDLE.
- mem_rvalid outside WAIT is ignored.

## Timing
- Reset values: state IDLE; req_ready=1 (combinational from state); busy, resp_valid, resp_err, mem_req, mem_we = 0; mem_be, mem_addr, mem_wdata, resp_rdata = 0.
- Cycle 0 accept; mem_req rises cycle 1 (registered outputs, no combinational path req_* → mem_*).
- Zero-wait store: gnt cycle 1, resp_valid cycle 2. Zero-wait load: gnt cycle 1, rvalid cycle 2, resp_valid cycle 3.
- Error: resp_valid+resp_err cycle 1, mem_req never asserted.
- Memory guarantees mem_rvalid no earlier than the cycle after mem_gnt.
- resp_rdata/resp_err valid only while resp_valid; held until next RESP.
- No back-to-back accept: earliest next accept is the cycle after RESP.
- Reset mid-transaction: all outputs return to reset values immediately; late mem_rvalid is dropped.

## Configuration
- LSU_TRACE_EN defined: extra outputs trc_wr, trc_rd (1 bit), trc_addr (ADDR_W), trc_wr_data, trc_rd_data (DATA_W), pulsing trc_wr on store grant and trc_rd on load rvalid with the access's address/data; zero otherwise and on reset.
- Not defined: ports absent, no trace logic.

## Structure
- Shared package lsu_pkg: state enum, size encodings (SZ_B/H/W/D), funct3 constants, function for size→byte-mask.
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension from mem_rdata, offset, funct3.

## Test plan
- DATA_W=32, SW addr 0x0000_0010 data 0xDEADBEEF, gnt cycle 1 → mem_addr 4, mem_be 1111, resp_valid cycle 2, resp_rdata 0.
- LB addr 0x13, mem_rdata 0x80FF_0000 after 3-cycle wait → mem_be 1000, resp_rdata 0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr 0x12 data 0x0000_ABCD → mem_be 1100, mem_wdata 0xABCD_xxxx lanes correct.
- LW addr 0x2 → resp_err=1 at cycle 1, mem_req stays 0; funct3 011 at DATA_W=32 → resp_err.
- DATA_W=64, LD addr 0x8 then LWU addr 0xC with rdata 0x8765_4321_xxxx → resp_rdata 0x0000_0000_8765_4321.
- Load in WAIT, reset low mid-wait, rvalid arrives after release → no resp_valid, req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM state codes,
// funct3 fields and the size-to-byte-mask helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // funct3[2] selects zero extension on loads; 111 has no meaning in either width.
    localparam int         F3_USGN = 2;
    localparam logic [2:0] F3_RSVD = 3'b111;

    function automatic logic [7:0] size_mask(input size_e size);
        case (size)
            SZ_B:    size_mask = 8'h01;
            SZ_H:    size_mask = 8'h03;
            SZ_W:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed lane out of a memory read word and sign- or zero-extends it
// to the full data width according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF    = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF-1:0]    off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;
    logic              sign_en;

    assign shifted = rdata >> {off, 3'b000};
    assign sign_en = ~funct3[F3_USGN];

    // Fill with the sign bit first, then overlay the live low bits of the lane.
    always_comb begin
        data = shifted;
        case (size_e'(funct3[1:0]))
            SZ_B: begin
                data       = {DATA_W{sign_en & shifted[7]}};
                data[7:0]  = shifted[7:0];
            end
            SZ_H: begin
                data       = {DATA_W{sign_en & shifted[15]}};
                data[15:0] = shifted[15:0];
            end
            SZ_W: begin
                data       = {DATA_W{sign_en & shifted[31]}};
                data[31:0] = shifted[31:0];
            end
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit between core and data memory with req/gnt/rvalid handshake.
// Optional trace outputs are built when LSU_TRACE_EN is defined.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef LSU_TRACE_EN
    ,
    output logic                  trc_wr,
    output logic                  trc_rd,
    output logic [ADDR_W-1:0]     trc_addr,
    output logic [DATA_W-1:0]     trc_wr_data,
    output logic [DATA_W-1:0]     trc_rd_data
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam int OFF  = $clog2(BE_W);

    logic [1:0]        state;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [OFF-1:0]    off_q;

    size_e             req_size;
    logic [OFF-1:0]    req_off;
    logic              misaligned;
    logic              illegal;
    logic [BE_W-1:0]   be_mask;
    logic [BE_W-1:0]   be_next;
    logic [DATA_W-1:0] wdata_next;
    logic [DATA_W-1:0] load_data;
    logic              unused_addr_hi;

    assign req_size = size_e'(req_funct3[1:0]);
    assign req_off  = req_addr[OFF-1:0];

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    assign unused_addr_hi = ^req_addr[DATA_W-1:ADDR_W+OFF];

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_H:    misaligned = req_addr[0];
            SZ_W:    misaligned = |req_addr[1:0];
            SZ_D:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign illegal = misaligned
                   | ((req_size == SZ_D) && (DATA_W == 32))
                   | (req_we & req_funct3[F3_USGN])
                   | ((DATA_W == 64) && (req_funct3 == F3_RSVD));

    assign be_mask = BE_W'(size_mask(req_size));
    assign be_next = be_mask << req_off;

    // Replicating the store value across the word lands it in every lane,
    // so the byte enables alone pick the right bytes.
    always_comb begin
        wdata_next = req_wdata;
        case (req_size)
            SZ_B:    wdata_next = {BE_W{req_wdata[7:0]}};
            SZ_H:    wdata_next = {(BE_W / 2){req_wdata[15:0]}};
            SZ_W:    wdata_next = {(BE_W / 4){req_wdata[31:0]}};
            default: wdata_next = req_wdata;
        endcase
    end

    lsu_load_align #(
        .DATA_W (DATA_W),
        .OFF    (OFF)
    ) u_load_align (
        .rdata  (mem_rdata),
        .off    (off_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        off_q    <= req_off;
                        if (illegal) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= be_next;
                            mem_addr  <= req_addr[ADDR_W+OFF-1:OFF];
                            mem_wdata <= wdata_next;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (we_q) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LSU_TRACE_EN
    assign trc_wr      = (state == ST_REQ) && mem_gnt && we_q;
    assign trc_rd      = (state == ST_WAIT) && mem_rvalid;
    assign trc_addr    = (trc_wr || trc_rd) ? mem_addr : '0;
    assign trc_wr_data = trc_wr ? mem_wdata : '0;
    assign trc_rd_data = trc_rd ? load_data : '0;
`endif

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: a 32-bit and a 64-bit instance share the request
// and memory-side stimulus; each is only handed a request through its own valid.
`timescale 1ns/1ps
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        v32, v64;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata, mem_rdata;
    logic        mem_gnt, mem_rvalid;

    logic        rdy32, rv32, err32, busy32, mreq32, mwe32;
    logic [31:0] rd32, wd32;
    logic [3:0]  be32;
    logic [8:0]  ma32;

    logic        rdy64, rv64, err64, busy64, mreq64, mwe64;
    logic [63:0] rd64, wd64;
    logic [7:0]  be64;
    logic [8:0]  ma64;

    int totalCount = 0;
    int badCount   = 0;

    always #5 clk = ~clk;

    lsu_mem_if #(.DATA_W(32), .ADDR_W(9)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(v32), .req_ready(rdy32), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(rv32), .resp_err(err32), .resp_rdata(rd32), .busy(busy32),
        .mem_req(mreq32), .mem_we(mwe32), .mem_be(be32), .mem_addr(ma32), .mem_wdata(wd32),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
    );

    lsu_mem_if #(.DATA_W(64), .ADDR_W(9)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(v64), .req_ready(rdy64), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv64), .resp_err(err64), .resp_rdata(rd64), .busy(busy64),
        .mem_req(mreq64), .mem_we(mwe64), .mem_be(be64), .mem_addr(ma64), .mem_wdata(wd64),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents one request for a single cycle; returns at the sample point of cycle 1.
    task automatic applyStimulus(input bit use64, input bit we, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        if (use64) v64 = 1'b1;
        else       v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        v64 = 1'b0;
        @(negedge clk);
    endtask

    task automatic grantCycle();
        mem_gnt = 1'b1;
        @(posedge clk);
        #1 mem_gnt = 1'b0;
        @(negedge clk);
    endtask

    task automatic rvalidCycle(input logic [63:0] data);
        mem_rdata  = data;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        v32 = 1'b0; v64 = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_ready",  {63'd0, rdy32},  64'd1);
        checkOutput("rst_busy",   {63'd0, busy32}, 64'd0);
        checkOutput("rst_rvalid", {63'd0, rv32},   64'd0);
        checkOutput("rst_memreq", {63'd0, mreq32}, 64'd0);
        checkOutput("rst_be",     {60'd0, be32},   64'd0);
        checkOutput("rst_wdata",  {32'd0, wd32},   64'd0);
        checkOutput("rst_rdata64", rd64,           64'd0);
        checkOutput("rst_ready64", {63'd0, rdy64}, 64'd1);
        reset = 1'b1;

        // SW 0x10, zero-wait grant
        applyStimulus(0, 1, 3'b010, 64'h10, 64'hDEADBEEF);
        checkOutput("sw_memreq", {63'd0, mreq32}, 64'd1);
        checkOutput("sw_memwe",  {63'd0, mwe32},  64'd1);
        checkOutput("sw_addr",   {55'd0, ma32},   64'd4);
        checkOutput("sw_be",     {60'd0, be32},   64'hF);
        checkOutput("sw_wdata",  {32'd0, wd32},   64'hDEADBEEF);
        checkOutput("sw_busy",   {63'd0, busy32}, 64'd1);
        checkOutput("sw_ready",  {63'd0, rdy32},  64'd0);
        grantCycle();
        checkOutput("sw_rvalid", {63'd0, rv32},   64'd1);
        checkOutput("sw_err",    {63'd0, err32},  64'd0);
        checkOutput("sw_rdata",  {32'd0, rd32},   64'd0);
        checkOutput("sw_reqdrop",{63'd0, mreq32}, 64'd0);

        // LB 0x13 with three idle wait cycles
        applyStimulus(0, 0, 3'b000, 64'h13, 64'h0);
        checkOutput("lb_be",     {60'd0, be32},   64'h8);
        checkOutput("lb_addr",   {55'd0, ma32},   64'd4);
        checkOutput("lb_memwe",  {63'd0, mwe32},  64'd0);
        grantCycle();
        checkOutput("lb_wait_rv",{63'd0, rv32},   64'd0);
        repeat (3) @(negedge clk);
        checkOutput("lb_wait_busy", {63'd0, busy32}, 64'd1);
        rvalidCycle(64'h80FF0000);
        checkOutput("lb_rvalid", {63'd0, rv32},   64'd1);
        checkOutput("lb_rdata",  {32'd0, rd32},   64'hFFFFFF80);
        // Stray rvalid in IDLE is ignored; resp_rdata holds
        rvalidCycle(64'h11111111);
        checkOutput("stray_rv",   {63'd0, rv32},  64'd0);
        checkOutput("stray_rdy",  {63'd0, rdy32}, 64'd1);
        checkOutput("hold_rdata", {32'd0, rd32},  64'hFFFFFF80);

        // LBU 0x13
        applyStimulus(0, 0, 3'b100, 64'h13, 64'h0);
        grantCycle();
        repeat (3) @(negedge clk);
        rvalidCycle(64'h80FF0000);
        checkOutput("lbu_rvalid", {63'd0, rv32}, 64'd1);
        checkOutput("lbu_rdata",  {32'd0, rd32}, 64'h00000080);

        // SH 0x12
        applyStimulus(0, 1, 3'b001, 64'h12, 64'h0000ABCD);
        checkOutput("sh_be",    {60'd0, be32},       64'hC);
        checkOutput("sh_lane",  {48'd0, wd32[31:16]}, 64'hABCD);
        grantCycle();
        checkOutput("sh_rvalid", {63'd0, rv32}, 64'd1);

        // Zero-wait LH 0x6: response in cycle 3
        applyStimulus(0, 0, 3'b001, 64'h6, 64'h0);
        checkOutput("lh_be", {60'd0, be32}, 64'hC);
        grantCycle();
        rvalidCycle(64'h80011234);
        checkOutput("lh_rvalid", {63'd0, rv32}, 64'd1);
        checkOutput("lh_rdata",  {32'd0, rd32}, 64'hFFFF8001);

        // Misaligned LW 0x2
        applyStimulus(0, 0, 3'b010, 64'h2, 64'h0);
        checkOutput("mis_rvalid", {63'd0, rv32},   64'd1);
        checkOutput("mis_err",    {63'd0, err32},  64'd1);
        checkOutput("mis_memreq", {63'd0, mreq32}, 64'd0);
        checkOutput("mis_rdata",  {32'd0, rd32},   64'd0);
        @(negedge clk);
        checkOutput("mis_pulse",  {63'd0, rv32},   64'd0);
        checkOutput("mis_memreq2",{63'd0, mreq32}, 64'd0);

        // Double on 32-bit, unsigned store
        applyStimulus(0, 0, 3'b011, 64'h0, 64'h0);
        checkOutput("ld32_err",    {63'd0, err32},  64'd1);
        checkOutput("ld32_memreq", {63'd0, mreq32}, 64'd0);
        applyStimulus(0, 1, 3'b100, 64'h0, 64'h0);
        checkOutput("su_err", {63'd0, err32}, 64'd1);
        checkOutput("su_rv",  {63'd0, rv32},  64'd1);

        // 64-bit: LD 0x8
        applyStimulus(1, 0, 3'b011, 64'h8, 64'h0);
        checkOutput("ld_addr", {55'd0, ma64}, 64'd1);
        checkOutput("ld_be",   {56'd0, be64}, 64'hFF);
        grantCycle();
        rvalidCycle(64'h87654321_00001111);
        checkOutput("ld_rvalid", {63'd0, rv64}, 64'd1);
        checkOutput("ld_rdata",  rd64,          64'h87654321_00001111);

        // LWU 0xC
        applyStimulus(1, 0, 3'b110, 64'hC, 64'h0);
        checkOutput("lwu_be", {56'd0, be64}, 64'hF0);
        grantCycle();
        rvalidCycle(64'h87654321_00001111);
        checkOutput("lwu_rdata", rd64, 64'h00000000_87654321);

        // LW 0xC signed
        applyStimulus(1, 0, 3'b010, 64'hC, 64'h0);
        grantCycle();
        rvalidCycle(64'h87654321_00001111);
        checkOutput("lw64_rdata", rd64, 64'hFFFFFFFF_87654321);

        // SB 0x5 on 64-bit
        applyStimulus(1, 1, 3'b000, 64'h5, 64'hAB);
        checkOutput("sb64_be",   {56'd0, be64},        64'h20);
        checkOutput("sb64_lane", {56'd0, wd64[47:40]}, 64'hAB);
        grantCycle();
        checkOutput("sb64_rv",   {63'd0, rv64}, 64'd1);

        // funct3 111 on 64-bit
        applyStimulus(1, 0, 3'b111, 64'h0, 64'h0);
        checkOutput("f7_err",    {63'd0, err64},  64'd1);
        checkOutput("f7_memreq", {63'd0, mreq64}, 64'd0);

        // Reset while waiting for read data
        applyStimulus(0, 0, 3'b010, 64'h4, 64'h0);
        grantCycle();
        checkOutput("rw_busy", {63'd0, busy32}, 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("rw_busy_rst",  {63'd0, busy32}, 64'd0);
        checkOutput("rw_ready_rst", {63'd0, rdy32},  64'd1);
        checkOutput("rw_be_rst",    {60'd0, be32},   64'd0);
        @(negedge clk);
        reset = 1'b1;
        rvalidCycle(64'h12345678);
        checkOutput("rw_late_rv", {63'd0, rv32},  64'd0);
        checkOutput("rw_ready",   {63'd0, rdy32}, 64'd1);
        checkOutput("rw_rdata",   {32'd0, rd32},  64'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
